gb_cpu_decoder: RTL and testbench

// - Instruction decoder/sequencer between the fetch byte stream and the execute stage (ALU/IDU/register file).
// - Assembles one SM83 instruction (opcode, optional CB opcode, 0/1/2 immediate bytes) into a registered record.
// - Derives control_signals_t fields and alu_opcode_t, then hands the record downstream via valid/ready.

---
 rtl/gb_cpu_common_pkg.sv | 71 +++++++
 rtl/gb_cpu_opcode_lut.sv | 78 +++++++
 rtl/gb_cpu_decoder.sv | 143 ++++++++++++++
 tb/tb_gb_cpu_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared SM83 core types: decoder FSM states, ALU opcodes, operand selectors and the
// decoded-instruction record handed from the decoder to the execute stage.
package gb_cpu_common_pkg;

    typedef enum logic [2:0] {
        READ_OPCODE,
        READ_CB_OPCODE,
        READ_R8,
        READ_R16_BYTE0,
        READ_R16_BYTE1
    } decoder_state_t;

    typedef enum logic [4:0] {
        ALU_NOP,
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR,
        ALU_RLCA, ALU_RRCA, ALU_RLA, ALU_RRA, ALU_DAA, ALU_CPL, ALU_SCF, ALU_CCF,
        ALU_RLC, ALU_RRC, ALU_RL, ALU_RR, ALU_SLA, ALU_SRA, ALU_SWAP, ALU_SRL,
        ALU_BIT, ALU_RESET, ALU_SET
    } alu_opcode_t;

    typedef enum logic [2:0] {
        r8_b, r8_c, r8_d, r8_e, r8_h, r8_l, r8_hl_ind, r8_a
    } r8_t;

    typedef enum logic [1:0] {r16_bc, r16_de, r16_hl, r16_sp} r16_t;
    typedef enum logic [1:0] {r16stk_bc, r16stk_de, r16stk_hl, r16stk_af} r16stk_t;
    typedef enum logic [1:0] {r16mem_bc, r16mem_de, r16mem_hli, r16mem_hld} r16mem_t;
    typedef enum logic [1:0] {cond_nz, cond_z, cond_nc, cond_c} cond_t;

    typedef struct packed {
        r8_t        r8;
        r16_t       r16;
        r16stk_t    r16stk;
        r16mem_t    r16mem;
        cond_t      cond;
        logic [2:0] bit_index;
        logic [7:0] rst_target_addr;
    } control_signals_t;

    localparam logic [7:0] OPCODE_CB_PREFIX = 8'hCB;

    typedef struct packed {
        logic [7:0]       opcode;
        logic             cb;
        logic [7:0]       cb_op;
        logic [15:0]      imm;
        logic [1:0]       imm_len;
        logic             illegal;
        alu_opcode_t      alu_op;
        control_signals_t ctrl;
    } decoded_instr_t;

    function automatic logic [1:0] opcode_imm_len(input logic [7:0] op);
        logic [1:0] len;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                len = 2'd1;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC,
            8'hEA, 8'hFA:
                len = 2'd2;
            default:
                len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/gb_cpu_opcode_lut.sv
// Combinational SM83 opcode table: immediate length, ALU operation, illegal flag and
// operand-selector fields for a primary or CB-prefixed opcode.
module gb_cpu_opcode_lut
    import gb_cpu_common_pkg::*;
(
    input  logic [7:0]       opcode,
    input  logic [7:0]       cb_op,
    input  logic             is_cb,
    output logic [1:0]       imm_len,
    output alu_opcode_t      alu_op,
    output logic             illegal,
    output control_signals_t ctrl
);

    logic [7:0] o;

    always_comb begin
        o       = is_cb ? cb_op : opcode;
        imm_len = is_cb ? 2'd0 : opcode_imm_len(opcode);
        illegal = !is_cb && (opcode inside {8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD});

        ctrl                 = '0;
        // Block 0 encodes its 8-bit register in the middle field; everything else uses the low one.
        ctrl.r8              = r8_t'((!is_cb && o[7:6] == 2'b00) ? o[5:3] : o[2:0]);
        ctrl.r16             = r16_t'(o[5:4]);
        ctrl.r16stk          = r16stk_t'(o[5:4]);
        ctrl.r16mem          = r16mem_t'(o[5:4]);
        ctrl.cond            = cond_t'(o[4:3]);
        ctrl.bit_index       = o[5:3];
        ctrl.rst_target_addr = {2'b00, o[5:3], 3'b000};

        alu_op = ALU_NOP;
        if (is_cb) begin
            unique case (o[7:6])
                2'b00: begin
                    unique case (o[5:3])
                        3'd0: alu_op = ALU_RLC;
                        3'd1: alu_op = ALU_RRC;
                        3'd2: alu_op = ALU_RL;
                        3'd3: alu_op = ALU_RR;
                        3'd4: alu_op = ALU_SLA;
                        3'd5: alu_op = ALU_SRA;
                        3'd6: alu_op = ALU_SWAP;
                        default: alu_op = ALU_SRL;
                    endcase
                end
                2'b01:   alu_op = ALU_BIT;
                2'b10:   alu_op = ALU_RESET;
                default: alu_op = ALU_SET;
            endcase
        end else if (o[7:6] == 2'b10 || (o[7:6] == 2'b11 && o[2:0] == 3'b110)) begin
            // CP shares the subtractor; execute discards the result.
            unique case (o[5:3])
                3'd0: alu_op = ALU_ADD;
                3'd1: alu_op = ALU_ADC;
                3'd2: alu_op = ALU_SUB;
                3'd3: alu_op = ALU_SBC;
                3'd4: alu_op = ALU_AND;
                3'd5: alu_op = ALU_XOR;
                3'd6: alu_op = ALU_OR;
                default: alu_op = ALU_SUB;
            endcase
        end else if (o[7:6] == 2'b00 && o[2:0] == 3'b111) begin
            unique case (o[5:3])
                3'd0: alu_op = ALU_RLCA;
                3'd1: alu_op = ALU_RRCA;
                3'd2: alu_op = ALU_RLA;
                3'd3: alu_op = ALU_RRA;
                3'd4: alu_op = ALU_DAA;
                3'd5: alu_op = ALU_CPL;
                3'd6: alu_op = ALU_SCF;
                default: alu_op = ALU_CCF;
            endcase
        end
    end

endmodule

// File: rtl/gb_cpu_decoder.sv
// SM83 instruction decoder: assembles opcode, CB opcode and immediates from the fetch byte
// stream into a registered record and hands it to execute over valid/ready.
module gb_cpu_decoder
    import gb_cpu_common_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [7:0]       instr_opcode,
    output logic             instr_cb,
    output logic [7:0]       instr_cb_op,
    output logic [15:0]      instr_imm,
    output logic [1:0]       instr_imm_len,
    output logic             instr_illegal,
    output alu_opcode_t      instr_alu_op,
    output control_signals_t instr_ctrl
);

    decoder_state_t   state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [7:0]       byte0_q, byte0_d;
    decoded_instr_t   rec_q, rec_d, new_rec;
    logic             valid_q, valid_d;
    logic             byte_xfer, complete;
    logic [7:0]       lut_opcode;
    logic             lut_is_cb;
    logic [1:0]       lut_imm_len;
    alu_opcode_t      lut_alu_op;
    logic             lut_illegal;
    control_signals_t lut_ctrl;

    assign byte_ready = !flush && (!valid_q || instr_ready);
    assign byte_xfer  = byte_valid && byte_ready;
    // In READ_OPCODE the incoming byte is the opcode, so decode it without waiting a cycle.
    assign lut_opcode = (state_q == READ_OPCODE) ? byte_data : opcode_q;
    assign lut_is_cb  = (state_q == READ_CB_OPCODE);

    gb_cpu_opcode_lut u_lut (
        .opcode  (lut_opcode),
        .cb_op   (byte_data),
        .is_cb   (lut_is_cb),
        .imm_len (lut_imm_len),
        .alu_op  (lut_alu_op),
        .illegal (lut_illegal),
        .ctrl    (lut_ctrl)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        byte0_d  = byte0_q;
        complete = 1'b0;
        if (byte_xfer) begin
            unique case (state_q)
                READ_OPCODE: begin
                    opcode_d = byte_data;
                    if (byte_data == OPCODE_CB_PREFIX) begin
                        state_d = READ_CB_OPCODE;
                    end else if (lut_imm_len == 2'd1) begin
                        state_d = READ_R8;
                    end else if (lut_imm_len == 2'd2) begin
                        state_d = READ_R16_BYTE0;
                    end else begin
                        complete = 1'b1;
                    end
                end
                READ_R16_BYTE0: begin
                    byte0_d = byte_data;
                    state_d = READ_R16_BYTE1;
                end
                READ_CB_OPCODE, READ_R8, READ_R16_BYTE1: begin
                    complete = 1'b1;
                    state_d  = READ_OPCODE;
                end
                default: state_d = READ_OPCODE;
            endcase
        end
        if (flush) begin
            state_d = READ_OPCODE;
        end
    end

    always_comb begin
        new_rec         = '0;
        new_rec.opcode  = lut_opcode;
        new_rec.cb      = lut_is_cb;
        new_rec.cb_op   = lut_is_cb ? byte_data : 8'h00;
        new_rec.imm_len = lut_imm_len;
        new_rec.illegal = lut_illegal;
        new_rec.alu_op  = lut_alu_op;
        new_rec.ctrl    = lut_ctrl;
        if (state_q == READ_R8) begin
            new_rec.imm = {8'h00, byte_data};
        end else if (state_q == READ_R16_BYTE1) begin
            new_rec.imm = {byte_data, byte0_q};
        end

        rec_d   = rec_q;
        valid_d = valid_q;
        if (valid_q && instr_ready) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            rec_d   = new_rec;
            valid_d = 1'b1;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= READ_OPCODE;
            opcode_q <= 8'h00;
            byte0_q  <= 8'h00;
            rec_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            byte0_q  <= byte0_d;
            rec_q    <= rec_d;
            valid_q  <= valid_d;
        end
    end

    assign instr_valid   = valid_q;
    assign instr_opcode  = rec_q.opcode;
    assign instr_cb      = rec_q.cb;
    assign instr_cb_op   = rec_q.cb_op;
    assign instr_imm     = rec_q.imm;
    assign instr_imm_len = rec_q.imm_len;
    assign instr_illegal = rec_q.illegal;
    assign instr_alu_op  = rec_q.alu_op;
    assign instr_ctrl    = rec_q.ctrl;

endmodule

// File: tb/tb_gb_cpu_decoder.sv
// Directed bench for gb_cpu_decoder: per-cycle vector table plus hand-written reset sequences.
module tb_gb_cpu_decoder;
    import gb_cpu_common_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             instr_valid;
    logic             instr_ready;
    logic [7:0]       instr_opcode;
    logic             instr_cb;
    logic [7:0]       instr_cb_op;
    logic [15:0]      instr_imm;
    logic [1:0]       instr_imm_len;
    logic             instr_illegal;
    alu_opcode_t      instr_alu_op;
    control_signals_t instr_ctrl;

    gb_cpu_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_cb      (instr_cb),
        .instr_cb_op   (instr_cb_op),
        .instr_imm     (instr_imm),
        .instr_imm_len (instr_imm_len),
        .instr_illegal (instr_illegal),
        .instr_alu_op  (instr_alu_op),
        .instr_ctrl    (instr_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          bv;
        logic [7:0]  data;
        bit          rdy;
        bit          fl;
        bit          e_br;
        bit          e_v;
        logic [7:0]  e_op;
        bit          e_cb;
        logic [7:0]  e_cbop;
        logic [15:0] e_imm;
        logic [1:0]  e_len;
        bit          e_ill;
        alu_opcode_t e_alu;
        logic [2:0]  e_r8;
        logic [1:0]  e_r16;
        logic [2:0]  e_bit;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic add(input string n, input bit bv, input logic [7:0] d, input bit rdy,
                       input bit fl, input bit br, input bit v, input logic [7:0] op,
                       input bit cb, input logic [7:0] cbop, input logic [15:0] imm,
                       input logic [1:0] len, input bit ill, input alu_opcode_t alu,
                       input logic [2:0] r8, input logic [1:0] r16, input logic [2:0] bi);
        vec_t t;
        t.name = n;   t.bv = bv;     t.data = d;     t.rdy = rdy;   t.fl = fl;
        t.e_br = br;  t.e_v = v;     t.e_op = op;    t.e_cb = cb;   t.e_cbop = cbop;
        t.e_imm = imm; t.e_len = len; t.e_ill = ill; t.e_alu = alu;
        t.e_r8 = r8;  t.e_r16 = r16; t.e_bit = bi;
        vecs.push_back(t);
    endtask

    task automatic idle(input string n, input bit bv, input logic [7:0] d, input bit rdy,
                        input bit fl, input bit br);
        add(n, bv, d, rdy, fl, br, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'd0, 1'b0, ALU_NOP,
            3'd0, 2'd0, 3'd0);
    endtask

    task automatic check_record(input string n, input logic [7:0] op, input bit cb,
                                input logic [7:0] cbop, input logic [15:0] imm,
                                input logic [1:0] len, input bit ill, input alu_opcode_t alu,
                                input logic [2:0] r8, input logic [1:0] r16,
                                input logic [2:0] bi);
        check({n, ".opcode"}, 32'(instr_opcode), 32'(op));
        check({n, ".cb"}, 32'(instr_cb), 32'(cb));
        check({n, ".cb_op"}, 32'(instr_cb_op), 32'(cbop));
        check({n, ".imm"}, 32'(instr_imm), 32'(imm));
        check({n, ".imm_len"}, 32'(instr_imm_len), 32'(len));
        check({n, ".illegal"}, 32'(instr_illegal), 32'(ill));
        check({n, ".alu_op"}, 32'(instr_alu_op), 32'(alu));
        check({n, ".r8"}, 32'(instr_ctrl.r8), 32'(r8));
        check({n, ".r16"}, 32'(instr_ctrl.r16), 32'(r16));
        check({n, ".bit_index"}, 32'(instr_ctrl.bit_index), 32'(bi));
    endtask

    task automatic drive(input bit bv, input logic [7:0] d, input bit rdy);
        @(negedge clk);
        byte_valid  = bv;
        byte_data   = d;
        instr_ready = rdy;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        instr_ready = 1'b1;

        // 1: back-to-back single-byte ops
        idle("t1_00", 1, 8'h00, 1, 0, 1);
        add("t1_3c", 1, 8'h3C, 1, 0, 1, 1, 8'h00, 0, 8'h00, 16'h0000, 2'd0, 0, ALU_NOP, 0, 0, 0);
        add("t1_rec", 0, 8'h00, 1, 0, 1, 1, 8'h3C, 0, 8'h00, 16'h0000, 2'd0, 0, ALU_NOP, 7, 3, 7);
        // 2: 16-bit immediate
        idle("t2_01", 1, 8'h01, 1, 0, 1);
        idle("t2_34", 1, 8'h34, 1, 0, 1);
        idle("t2_12", 1, 8'h12, 1, 0, 1);
        add("t2_rec", 0, 8'h00, 1, 0, 1, 1, 8'h01, 0, 8'h00, 16'h1234, 2'd2, 0, ALU_NOP, 0, 0, 0);
        // 3: CB prefix
        idle("t3_cb", 1, 8'hCB, 1, 0, 1);
        idle("t3_7c", 1, 8'h7C, 1, 0, 1);
        add("t3_rec", 0, 8'h00, 1, 0, 1, 1, 8'hCB, 1, 8'h7C, 16'h0000, 2'd0, 0, ALU_BIT, 4, 3, 7);
        // 4: record held under backpressure while fetch keeps offering a byte
        idle("t4_fe", 1, 8'hFE, 1, 0, 1);
        idle("t4_05", 1, 8'h05, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            add($sformatf("t4_hold%0d", i), 1, 8'h00, 0, 0, 0, 1, 8'hFE, 0, 8'h00, 16'h0005,
                2'd1, 0, ALU_SUB, 6, 3, 7);
        end
        add("t4_take", 0, 8'h00, 1, 0, 1, 1, 8'hFE, 0, 8'h00, 16'h0005, 2'd1, 0, ALU_SUB, 6, 3, 7);
        idle("t4_gone", 0, 8'h00, 1, 0, 1);
        // 5: flush abandons a partial JP
        idle("t5_c3", 1, 8'hC3, 1, 0, 1);
        idle("t5_lo", 1, 8'h00, 1, 0, 1);
        idle("t5_flush", 1, 8'h00, 1, 1, 0);
        idle("t5_18", 1, 8'h18, 1, 0, 1);
        idle("t5_fe", 1, 8'hFE, 1, 0, 1);
        add("t5_rec", 0, 8'h00, 1, 0, 1, 1, 8'h18, 0, 8'h00, 16'h00FE, 2'd1, 0, ALU_NOP, 3, 1, 3);
        idle("t5_gone", 0, 8'h00, 1, 0, 1);
        // 6: illegal opcode, left held for the async-reset check below
        idle("t6_d3", 1, 8'hD3, 1, 0, 1);
        add("t6_rec", 0, 8'h00, 0, 0, 0, 1, 8'hD3, 0, 8'h00, 16'h0000, 2'd0, 1, ALU_NOP, 3, 1, 2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.valid", 32'(instr_valid), 32'd0);
        check("reset.byte_ready", 32'(byte_ready), 32'd1);
        check_record("reset", 8'h00, 0, 8'h00, 16'h0000, 2'd0, 0, ALU_NOP, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            byte_valid  = vecs[i].bv;
            byte_data   = vecs[i].data;
            instr_ready = vecs[i].rdy;
            flush       = vecs[i].fl;
            #1;
            check({vecs[i].name, ".byte_ready"}, 32'(byte_ready), 32'(vecs[i].e_br));
            check({vecs[i].name, ".valid"}, 32'(instr_valid), 32'(vecs[i].e_v));
            if (vecs[i].e_v) begin
                check_record(vecs[i].name, vecs[i].e_op, vecs[i].e_cb, vecs[i].e_cbop,
                             vecs[i].e_imm, vecs[i].e_len, vecs[i].e_ill, vecs[i].e_alu,
                             vecs[i].e_r8, vecs[i].e_r16, vecs[i].e_bit);
            end
        end
        flush = 1'b0;

        // Async reset drops a held record without waiting for a clock edge.
        #1;
        check("hold_pre_reset.valid", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset.valid", 32'(instr_valid), 32'd0);
        check("async_reset.opcode", 32'(instr_opcode), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset while waiting for the high immediate byte: the next byte must be an opcode.
        drive(1, 8'h01, 1);
        drive(1, 8'h34, 1);
        drive(0, 8'h00, 1);
        reset = 1'b1;
        #1;
        check("mid_reset.valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 8'h3C, 1);
        #1;
        check("post_reset.no_record", 32'(instr_valid), 32'd0);
        drive(0, 8'h00, 1);
        #1;
        check("post_reset.valid", 32'(instr_valid), 32'd1);
        check_record("post_reset", 8'h3C, 0, 8'h00, 16'h0000, 2'd0, 0, ALU_NOP, 7, 3, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
